// File: rtl/int_ctrl.sv
// int_ctrl -- prioritised interrupt controller with mask, global enable and
// a single-level (non-nesting) request/acknowledge/return handshake.
//
// Optional feature macro: INT_EDGE_DETECT_EN
//   defined   : a source is "active" on a 0->1 transition of hw_int (one
//               history flop per source).
//   undefined : a source is "active" whenever hw_int is high (level).
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous active-low reset
//   hw_int     interrupt sources, index 0 is highest priority
//   we/addr/wdata  register write port (0=CTRL, 1=PEND, 2=CUR, 3=reserved)
//   rdata      combinational read data for addr
//   irq        registered interrupt request to the CPU
//   irq_code   index of the source requested / in service
//   irq_ack    CPU accepts the request (pulse)
//   eret       CPU returns from handler (pulse)
//   in_service high while a handler is active
module int_ctrl #(
  parameter int NINT = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NINT-1:0] hw_int,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            irq,
  output logic [2:0]      irq_code,
  input  logic            irq_ack,
  input  logic            eret,
  output logic            in_service
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  state_t          r_state, w_state_nxt;
  logic [NINT-1:0] r_pend, r_mask;
  logic            r_gie;
  logic [2:0]      r_code, w_code_nxt, w_win;
  logic            r_irq, r_insvc;
  logic [NINT-1:0] w_act, w_elig, w_w1c, w_ack_clr;

`ifdef INT_EDGE_DETECT_EN
  logic [NINT-1:0] r_hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_hist <= '0;
    else        r_hist <= hw_int;
  end

  assign w_act = hw_int & ~r_hist;
`else
  assign w_act = hw_int;
`endif

  // Arbitration always looks at the registered MASK/GIE, so a CTRL write
  // only changes the decision from the following cycle on.
  assign w_elig = r_gie ? (r_pend & r_mask) : '0;

  // Lowest eligible index wins; scan from the top so index 0 lands last.
  always_comb begin
    w_win = '0;
    for (int i = NINT - 1; i >= 0; i--)
      if (w_elig[i]) w_win = 3'(i);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_ack_clr   = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_elig != '0) begin
          w_state_nxt = S_REQ;
          w_code_nxt  = w_win;
        end
      end
      S_REQ: begin
        // A withdrawn request takes precedence over a same-cycle ack.
        if (w_elig == '0) begin
          w_state_nxt = S_IDLE;
        end else if (irq_ack) begin
          w_state_nxt = S_SERVICE;
          for (int i = 0; i < NINT; i++)
            if (r_code == 3'(i)) w_ack_clr[i] = 1'b1;
        end else begin
          w_code_nxt = w_win;
        end
      end
      S_SERVICE: begin
        if (eret) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_w1c = (we && addr == 2'd1) ? wdata[NINT-1:0] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_code  <= '0;
      r_pend  <= '0;
      r_mask  <= '0;
      r_gie   <= 1'b0;
      r_irq   <= 1'b0;
      r_insvc <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_irq   <= (w_state_nxt == S_REQ);
      r_insvc <= (w_state_nxt == S_SERVICE);
      // New activity wins over both software clear and ack clear.
      r_pend  <= (r_pend & ~w_w1c & ~w_ack_clr) | w_act;
      if (we && addr == 2'd0) begin
        r_mask <= wdata[NINT-1:0];
        r_gie  <= wdata[31];
      end
    end
  end

  assign irq        = r_irq;
  assign in_service = r_insvc;
  assign irq_code   = r_code;

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0: begin
        rdata[NINT-1:0] = r_mask;
        rdata[31]       = r_gie;
      end
      2'd1: rdata[NINT-1:0] = r_pend;
      2'd2: begin
        rdata[2:0] = r_code;
        rdata[31]  = r_insvc;
      end
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the controller.
module tb_int_ctrl;
  localparam int NINT = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic [NINT-1:0] hw_int;
  logic            we;
  logic [1:0]      addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            irq;
  logic [2:0]      irq_code;
  logic            irq_ack;
  logic            eret;
  logic            in_service;

  int n_chk = 0;
  int n_fail = 0;

  int m_st;            // 0 idle, 1 requesting, 2 servicing
  int m_code;
  bit m_gie;
  bit m_pend [NINT];
  bit m_mask [NINT];
  bit m_hist [NINT];

  int_ctrl #(.NINT(NINT)) dut (
    .clk(clk), .reset(reset), .hw_int(hw_int), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .irq(irq), .irq_code(irq_code),
    .irq_ack(irq_ack), .eret(eret), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_code = 0; m_gie = 0;
    for (int i = 0; i < NINT; i++) begin
      m_pend[i] = 0; m_mask[i] = 0; m_hist[i] = 0;
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      2'd0: begin
        for (int i = 0; i < NINT; i++) v[i] = m_mask[i];
        v[31] = m_gie;
      end
      2'd1: for (int i = 0; i < NINT; i++) v[i] = m_pend[i];
      2'd2: begin
        v[2:0] = m_code[2:0];
        v[31]  = (m_st == 2);
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  // One clock edge of the controller, driven by the inputs now applied.
  task automatic model_step();
    bit act [NINT];
    int win, nst, ncode, clr;
    bit w1c;
    win = -1; clr = -1;
    for (int i = 0; i < NINT; i++) begin
`ifdef INT_EDGE_DETECT_EN
      act[i] = hw_int[i] && !m_hist[i];
`else
      act[i] = hw_int[i];
`endif
      if (win < 0 && m_gie && m_pend[i] && m_mask[i]) win = i;
    end
    nst = m_st; ncode = m_code;
    if (m_st == 0) begin
      if (win >= 0) begin nst = 1; ncode = win; end
    end else if (m_st == 1) begin
      if (win < 0) nst = 0;
      else if (irq_ack) begin nst = 2; clr = m_code; end
      else ncode = win;
    end else if (eret) begin
      nst = 0;
    end
    for (int i = 0; i < NINT; i++) begin
      w1c = we && addr == 2'd1 && wdata[i];
      m_pend[i] = act[i] || (m_pend[i] && !w1c && i != clr);
      m_hist[i] = hw_int[i];
    end
    if (we && addr == 2'd0) begin
      for (int i = 0; i < NINT; i++) m_mask[i] = wdata[i];
      m_gie = wdata[31];
    end
    m_st = nst; m_code = ncode;
  endtask

  task automatic cmp_all();
    chk("irq", irq, (m_st == 1));
    chk("irq_code", irq_code, m_code);
    chk("in_service", in_service, (m_st == 2));
    chk("rdata", rdata, m_read(addr));
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    cyc();
    we = 1'b0;
  endtask

  initial begin
    reset = 1'b0; hw_int = '0; we = 1'b0; addr = '0; wdata = '0;
    irq_ack = 1'b0; eret = 1'b0;
    m_reset();
    #12;
    cmp_all();
    chk("reset irq", irq, 0);
    reset = 1'b1;

    // Single pulse on source 2: two-edge latency, ack, return.
    wr(2'd0, 32'h8000_0004);
    hw_int = 6'b000100; cyc();
    chk("031 irq after E0", irq, 0);
    hw_int = '0; cyc();
    chk("031 irq after E1", irq, 1);
    chk("031 code", irq_code, 2);
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    chk("031 in_service", in_service, 1);
    addr = 2'd1; #1;
    chk("031 pend", rdata, 0);
    eret = 1'b1; cyc(); eret = 1'b0;
    chk("031 insvc off", in_service, 0);
    cyc();
    chk("031 irq stays 0", irq, 0);

    // Two simultaneous sources: 1 first, 5 one edge after return.
    wr(2'd0, 32'h8000_003F);
    hw_int = 6'b100010; cyc();
    hw_int = '0; cyc();
    chk("032 code1", irq_code, 1);
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    eret = 1'b1; cyc(); eret = 1'b0;
    chk("032 idle irq", irq, 0);
    cyc();
    chk("032 irq again", irq, 1);
    chk("032 code5", irq_code, 5);
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    eret = 1'b1; cyc(); eret = 1'b0;

    // Global disable while requesting source 3.
    hw_int = 6'b001000; cyc();
    hw_int = '0; cyc();
    chk("033 code3", irq_code, 3);
    wr(2'd0, 32'h0000_003F);
    chk("033 pre-write still req", irq, 1);
    cyc();
    chk("033 irq dropped", irq, 0);
    chk("033 not in service", in_service, 0);
    addr = 2'd1; #1;
    chk("033 pend3 kept", rdata & 32'h8, 32'h8);
    wr(2'd1, 32'h3F);
    wr(2'd0, 32'h8000_003F);

    // Set wins over a same-edge PEND clear while servicing.
    hw_int = 6'b000001; cyc();
    hw_int = '0; cyc();
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    hw_int = 6'b010000; cyc();
    hw_int = '0; cyc();
    hw_int = 6'b010000; we = 1'b1; addr = 2'd1; wdata = 32'h10; cyc();
    we = 1'b0; hw_int = '0; #1;
    chk("034 pend4 set wins", rdata & 32'h10, 32'h10);
    chk("034 still servicing", in_service, 1);

    // Asynchronous reset between edges while servicing.
    #2;
    reset = 1'b0; #1;
    chk("035 irq", irq, 0);
    chk("035 in_service", in_service, 0);
    for (int a = 0; a < 3; a++) begin
      addr = 2'(a); #1;
      chk("035 rdata", rdata, 0);
    end
    m_reset();
    #1 reset = 1'b1;

    // Source 0 held high through ack and a PEND clear.
    wr(2'd0, 32'h8000_0001);
    hw_int = 6'b000001; cyc();
    cyc();
    chk("036 req", irq, 1);
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    wr(2'd1, 32'h1);
    for (int k = 0; k < 6; k++) cyc();
    hw_int = '0;
    eret = 1'b1; cyc(); eret = 1'b0;
    cyc();
`ifdef INT_EDGE_DETECT_EN
    chk("036 no re-request", irq, 0);
`else
    chk("036 re-request", irq, 1);
`endif

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      hw_int  = ($urandom_range(3) == 0) ? NINT'($urandom) : '0;
      we      = ($urandom_range(5) == 0);
      addr    = 2'($urandom);
      wdata   = $urandom | (($urandom_range(3) != 0) ? 32'h8000_0000 : 32'h0);
      irq_ack = ($urandom_range(2) == 0);
      eret    = ($urandom_range(3) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
